// File: rtl/sram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_arb_pkg                                                         |
// | Shared constants and helpers for the SRAM-bus arbiter.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package sram_arb_pkg;

   localparam int DEFAULT_MAXOUT = 4;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_arb_id_fifo                                                     |
// | Requester-ID FIFO for outstanding reads; head is valid when !empty.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sram_arb_id_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_bus_arbiter                                                     |
// | Round-robin share of one SRAM-bus slave with in-order read routing.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sram_bus_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int DW     = 32,
   parameter int AW     = 32,
   parameter int MAXOUT = DEFAULT_MAXOUT
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic [NREQ-1:0]        m_req,
   input  logic [NREQ-1:0]        m_write,
   input  logic [NREQ*DW/8-1:0]   m_wstrb,
   input  logic [NREQ*AW-1:0]     m_addr,
   input  logic [NREQ*DW-1:0]     m_wdata,
   output logic [NREQ-1:0]        m_ready,
   output logic [NREQ-1:0]        m_rvalid,
   output logic [DW-1:0]          m_rdata,
   output logic                   sram_req,
   output logic                   sram_write,
   output logic [DW/8-1:0]        sram_wstrb,
   output logic [AW-1:0]          sram_addr,
   output logic [DW-1:0]          sram_wdata,
   input  logic                   sram_ready,
   input  logic                   sram_rvalid,
   input  logic [DW-1:0]          sram_rdata,
   output logic                   arb_err
);

   localparam int SW = DW/8;
   localparam int IW = id_width(NREQ);

   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   grant;
   logic            found;
   logic [NREQ-1:0] eligible;
   logic            fifo_full, fifo_empty;
   logic            push, pop, accept;
   logic [IW-1:0]   head_id;
   logic            arb_err_q, arb_err_d;

   // Reads need a free ID slot; a pop in the same cycle does not free one.
   assign eligible = m_req & (m_write | {NREQ{~fifo_full}});

   always_comb begin : p_grant
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            grant = IW'(idx);
         end
      end
   end

   always_comb begin
      sram_req   = found;
      sram_write = 1'b0;
      sram_wstrb = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      m_ready    = '0;
      if (found) begin
         sram_write     = m_write[grant];
         sram_wstrb     = m_wstrb[int'(grant)*SW +: SW];
         sram_addr      = m_addr[int'(grant)*AW +: AW];
         sram_wdata     = m_wdata[int'(grant)*DW +: DW];
         m_ready[grant] = sram_ready;
      end
   end

   assign accept = found & sram_ready;
   assign push   = accept & ~sram_write;
   assign pop    = sram_rvalid & ~fifo_empty;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = (grant == IW'(NREQ-1)) ? '0 : grant + 1'b1;
   end

   always_comb begin
      m_rvalid = '0;
      m_rdata  = '0;
      if (pop) begin
         m_rvalid[head_id] = 1'b1;
         m_rdata           = sram_rdata;
      end
   end

   assign arb_err_d = arb_err_q | (sram_rvalid & fifo_empty);
   assign arb_err   = arb_err_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ptr_q     <= '0;
         arb_err_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         arb_err_q <= arb_err_d;
      end
   end

   sram_arb_id_fifo #(
      .DEPTH (MAXOUT),
      .W     (IW)
   ) u_id_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push_i  (push),
      .din_i   (grant),
      .pop_i   (pop),
      .dout_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule
`default_nettype wire
